// File: rtl/satswarmv2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : satswarmv2_pkg
// Description : Shared types for the satswarm v2 mesh: packet layout, message
//               types, directional port indices and the port-direction type.
// Revision    : 1.0 - initial release
// ============================================================================
package satswarmv2_pkg;

    // Directional tx port indices on the mesh router
    localparam int PORT_W = 0;
    localparam int PORT_E = 1;
    localparam int PORT_S = 2;
    localparam int PORT_N = 3;

    typedef logic [1:0] noc_dir_t;

    // MSG_STATUS encodes to zero so an all-zero packet is a status packet.
    typedef enum logic [2:0] {
        MSG_STATUS    = 3'd0,
        MSG_CLAUSE    = 3'd1,
        MSG_HEARTBEAT = 3'd2,
        MSG_CONTROL   = 3'd3
    } msg_type_t;

    typedef struct packed {
        msg_type_t   msg_type;
        logic [7:0]  src_id;
        logic [7:0]  dst_id;
        logic [31:0] payload;
    } noc_packet_t;

    localparam noc_packet_t c_PKT_RESET = '{
        msg_type: MSG_STATUS,
        src_id:   8'd0,
        dst_id:   8'd0,
        payload:  32'd0
    };

endpackage
`default_nettype wire

// File: rtl/noc_egress_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter. Picks the first asserted
//               request starting at i_ptr and wrapping modulo NUM_REQ.
// Ports       : i_req   - request vector
//               i_ptr   - highest-priority index this cycle
//               o_grant - one-hot grant
//               o_idx   - encoded index of the granted request
//               o_valid - at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    localparam logic [IDX_W:0] c_NUM = (IDX_W + 1)'(NUM_REQ);

    logic [IDX_W:0] w_pos;

    // Scan from the farthest offset back to offset 0 so the candidate
    // closest to the pointer is the last one written and therefore wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_pos   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_pos = {1'b0, i_ptr} + (IDX_W + 1)'(k);
            if (w_pos >= c_NUM) begin
                w_pos = w_pos - c_NUM;
            end
            if (i_req[w_pos[IDX_W-1:0]]) begin
                o_grant                    = '0;
                o_grant[w_pos[IDX_W-1:0]]  = 1'b1;
                o_idx                      = w_pos[IDX_W-1:0];
                o_valid                    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/noc_egress_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : noc_egress_arbiter
// Description : Per-core egress scheduler for the four mesh tx ports
//               (3=N, 2=S, 1=E, 0=W). One round-robin arbiter per port shares
//               the port among NUM_REQ requesters; each port has an output
//               register. Traffic to disabled (off-grid) ports is accepted and
//               discarded, and counted in a saturating drop counter.
// Ports       : clk, rst        - clock, async active-high reset
//               i_req_pkt/dir/valid, o_req_ready - requester side
//               i_port_enable   - 1 = neighbour exists on that side
//               o_tx_pkt/valid, i_tx_ready      - mesh core_tx side
//               o_drop_cnt      - saturating dropped-packet count
// Revision    : 1.0 - initial release
// ============================================================================
module noc_egress_arbiter
    import satswarmv2_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DROP_CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  noc_packet_t [NUM_REQ-1:0] i_req_pkt,
    input  noc_dir_t    [NUM_REQ-1:0] i_req_dir,
    input  logic        [NUM_REQ-1:0] i_req_valid,
    output logic        [NUM_REQ-1:0] o_req_ready,
    input  logic        [3:0]         i_port_enable,
    output noc_packet_t [3:0]         o_tx_pkt,
    output logic        [3:0]         o_tx_valid,
    input  logic        [3:0]         i_tx_ready,
    output logic [DROP_CNT_W-1:0]     o_drop_cnt
);

    localparam int c_NUM_PORTS = 4;
    localparam int IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SUM_W       = $clog2(NUM_REQ + c_NUM_PORTS + 1);
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(NUM_REQ - 1);

    logic        [c_NUM_PORTS-1:0] r_tx_valid;
    noc_packet_t [c_NUM_PORTS-1:0] r_tx_pkt;
    logic [IDX_W-1:0]              r_ptr [c_NUM_PORTS];
    logic [DROP_CNT_W-1:0]         r_drop_cnt;

    logic [NUM_REQ-1:0]            w_cand    [c_NUM_PORTS];
    logic [NUM_REQ-1:0]            w_grant   [c_NUM_PORTS];
    logic [IDX_W-1:0]              w_idx     [c_NUM_PORTS];
    logic [IDX_W-1:0]              w_ptr_nxt [c_NUM_PORTS];
    logic [c_NUM_PORTS-1:0]        w_has;
    logic [c_NUM_PORTS-1:0]        w_can_load;
    logic [c_NUM_PORTS-1:0]        w_load;
    logic [c_NUM_PORTS-1:0]        w_flush;
    logic [NUM_REQ-1:0]            w_drop_req;
    logic [SUM_W-1:0]              w_drop_sum;
    logic [DROP_CNT_W:0]           w_drop_ext;
    logic [DROP_CNT_W-1:0]         w_drop_nxt;

    // Route each valid request either to its port's candidate set or, when
    // that port is off-grid, straight to the drop set.
    always_comb begin
        for (int p = 0; p < c_NUM_PORTS; p++) begin
            w_cand[p] = '0;
        end
        w_drop_req = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i_req_valid[i]) begin
                if (i_port_enable[i_req_dir[i]]) begin
                    w_cand[i_req_dir[i]][i] = 1'b1;
                end else begin
                    w_drop_req[i] = 1'b1;
                end
            end
        end
    end

    generate
        for (genvar p = 0; p < c_NUM_PORTS; p++) begin : g_port
            rr_arbiter #(
                .NUM_REQ (NUM_REQ),
                .IDX_W   (IDX_W)
            ) u_rr_arbiter (
                .i_req   (w_cand[p]),
                .i_ptr   (r_ptr[p]),
                .o_grant (w_grant[p]),
                .o_idx   (w_idx[p]),
                .o_valid (w_has[p])
            );

            assign w_can_load[p] = i_port_enable[p] && (!r_tx_valid[p] || i_tx_ready[p]);
            assign w_load[p]     = w_can_load[p] && w_has[p];
            // A held packet on a port that just went off-grid is discarded.
            assign w_flush[p]    = !i_port_enable[p] && r_tx_valid[p];
            assign w_ptr_nxt[p]  = (w_idx[p] == c_LAST_IDX) ? '0 : w_idx[p] + 1'b1;
        end
    endgenerate

    always_comb begin
        o_req_ready = '0;
        if (!rst) begin
            o_req_ready = w_drop_req;
            for (int p = 0; p < c_NUM_PORTS; p++) begin
                if (w_load[p]) begin
                    o_req_ready = o_req_ready | w_grant[p];
                end
            end
        end
    end

    // All drop sources of a cycle are summed first, then saturated once.
    always_comb begin
        w_drop_sum = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_drop_sum = w_drop_sum + SUM_W'(w_drop_req[i]);
        end
        for (int p = 0; p < c_NUM_PORTS; p++) begin
            w_drop_sum = w_drop_sum + SUM_W'(w_flush[p]);
        end
        w_drop_ext = {1'b0, r_drop_cnt} + (DROP_CNT_W + 1)'(w_drop_sum);
        w_drop_nxt = w_drop_ext[DROP_CNT_W] ? '1 : w_drop_ext[DROP_CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_valid <= '0;
            r_drop_cnt <= '0;
            for (int p = 0; p < c_NUM_PORTS; p++) begin
                r_tx_pkt[p] <= c_PKT_RESET;
                r_ptr[p]    <= '0;
            end
        end else begin
            r_drop_cnt <= w_drop_nxt;
            for (int p = 0; p < c_NUM_PORTS; p++) begin
                if (!i_port_enable[p]) begin
                    r_tx_valid[p] <= 1'b0;
                end else if (w_load[p]) begin
                    r_tx_valid[p] <= 1'b1;
                    r_tx_pkt[p]   <= i_req_pkt[w_idx[p]];
                    r_ptr[p]      <= w_ptr_nxt[p];
                end else if (i_tx_ready[p]) begin
                    r_tx_valid[p] <= 1'b0;
                end
            end
        end
    end

    assign o_tx_valid = r_tx_valid;
    assign o_tx_pkt   = r_tx_pkt;
    assign o_drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_noc_egress_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_egress_arbiter
// Description : Directed self-checking bench for noc_egress_arbiter. Granted
//               packets are queued per port and compared against the port
//               output register; drop count is tracked alongside.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_egress_arbiter;
    import satswarmv2_pkg::*;

    localparam int NUM_REQ    = 4;
    localparam int DROP_CNT_W = 16;

    logic                      clk = 1'b0;
    logic                      rst = 1'b1;
    noc_packet_t [NUM_REQ-1:0] req_pkt;
    noc_dir_t    [NUM_REQ-1:0] req_dir;
    logic        [NUM_REQ-1:0] req_valid;
    logic        [NUM_REQ-1:0] req_ready;
    logic        [3:0]         port_enable;
    noc_packet_t [3:0]         tx_pkt;
    logic        [3:0]         tx_valid;
    logic        [3:0]         tx_ready;
    logic [DROP_CNT_W-1:0]     drop_cnt;

    int checks   = 0;
    int failures = 0;
    noc_packet_t           q [4][$];
    logic [DROP_CNT_W-1:0] exp_drop;

    always #5 clk = ~clk;

    noc_egress_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DROP_CNT_W (DROP_CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_req_pkt     (req_pkt),
        .i_req_dir     (req_dir),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_port_enable (port_enable),
        .o_tx_pkt      (tx_pkt),
        .o_tx_valid    (tx_valid),
        .i_tx_ready    (tx_ready),
        .o_drop_cnt    (drop_cnt)
    );

    function automatic noc_packet_t mk(input int r, input int s);
        noc_packet_t p;
        p.msg_type = MSG_CLAUSE;
        p.src_id   = 8'(r);
        p.dst_id   = 8'(s);
        p.payload  = 32'hC0DE_0000 + 32'(s * 16 + r);
        return p;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input int i, input int dir, input int s);
        req_valid[i] = 1'b1;
        req_dir[i]   = noc_dir_t'(dir);
        req_pkt[i]   = mk(i, s);
    endtask

    task automatic inc_drop();
        if (exp_drop != '1) exp_drop = exp_drop + 1'b1;
    endtask

    task automatic check_tx(input string tag);
        for (int p = 0; p < 4; p++) begin
            chk($sformatf("%s.txv%0d", tag, p), 64'(tx_valid[p]), 64'(q[p].size() > 0));
            if (q[p].size() > 0)
                chk($sformatf("%s.pkt%0d", tag, p), 64'(tx_pkt[p]), 64'(q[p][0]));
        end
    endtask

    // Called just after inputs are driven (posedge+1). Checks the expected
    // req_ready, advances the scoreboard across one clock edge and checks
    // the registered outputs afterwards.
    task automatic cycle(input string tag, input logic [NUM_REQ-1:0] exp_rdy);
        #1;
        chk({tag, ".rdy"}, 64'(req_ready), 64'(exp_rdy));
        for (int p = 0; p < 4; p++) begin
            if (!port_enable[p]) begin
                if (q[p].size() > 0) begin
                    q[p].delete();
                    inc_drop();
                end
            end else if (q[p].size() > 0 && tx_ready[p]) begin
                void'(q[p].pop_front());
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (exp_rdy[i] && req_valid[i]) begin
                if (port_enable[req_dir[i]]) q[req_dir[i]].push_back(req_pkt[i]);
                else inc_drop();
            end
        end
        @(posedge clk);
        #1;
        check_tx(tag);
        chk({tag, ".drop"}, 64'(drop_cnt), 64'(exp_drop));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rem;
        req_valid   = '0;
        req_dir     = '0;
        req_pkt     = '0;
        port_enable = 4'hF;
        tx_ready    = 4'h0;
        exp_drop    = '0;

        // Reset state; a valid request during reset must not be accepted
        @(posedge clk);
        #1;
        req(0, PORT_E, 1);
        #1;
        chk("rst.rdy",  64'(req_ready), 64'd0);
        chk("rst.txv",  64'(tx_valid),  64'd0);
        chk("rst.drop", 64'(drop_cnt),  64'd0);
        for (int p = 0; p < 4; p++)
            chk($sformatf("rst.pkt%0d", p), 64'(tx_pkt[p]), 64'd0);
        req_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single requester to E, one-cycle latency
        tx_ready = 4'hF;
        req(0, PORT_E, 1);
        cycle("t1.a", 4'b0001);
        req_valid = '0;
        cycle("t1.b", 4'b0000);

        // Four requesters contend for N: grants 0,1,2,3,0
        for (int i = 0; i < NUM_REQ; i++) req(i, PORT_N, 10 + i);
        for (int k = 0; k < 5; k++)
            cycle($sformatf("t2.%0d", k), 4'(1 << (k % 4)));
        req_valid = '0;
        cycle("t2.end", 4'b0000);

        // Backpressure on S
        tx_ready[2] = 1'b0;
        req(2, PORT_S, 20);
        cycle("t3.load", 4'b0100);
        req(0, PORT_S, 21);
        req(2, PORT_S, 22);
        for (int k = 0; k < 5; k++)
            cycle($sformatf("t3.hold%0d", k), 4'b0000);
        tx_ready[2] = 1'b1;
        cycle("t3.rel", 4'b0001);
        req_valid[0] = 1'b0;
        cycle("t3.next", 4'b0100);
        req_valid = '0;
        cycle("t3.drain", 4'b0000);

        // Requests to an off-grid W are accepted and dropped
        port_enable = 4'b0110;
        req(0, PORT_W, 30);
        req(1, PORT_W, 31);
        cycle("t4", 4'b0011);
        chk("t4.two", 64'(drop_cnt), 64'd2);
        req_valid   = '0;
        port_enable = 4'hF;

        // Held packet on N flushed by disable, plus a same-cycle drop
        tx_ready[3] = 1'b0;
        req(1, PORT_N, 40);
        cycle("t5.load", 4'b0010);
        req_valid = '0;
        cycle("t5.hold", 4'b0000);
        port_enable[3] = 1'b0;
        req(2, PORT_N, 41);
        cycle("t5.flush", 4'b0100);
        chk("t5.four", 64'(drop_cnt), 64'd4);
        // Pointer on N must not have moved past requester 2
        port_enable = 4'hF;
        tx_ready    = 4'hF;
        req(1, PORT_N, 42);
        req(2, PORT_N, 43);
        cycle("t5.ptr", 4'b0100);
        req_valid[2] = 1'b0;
        cycle("t5.ptr2", 4'b0010);
        req_valid = '0;
        cycle("t5.drain", 4'b0000);

        // Drop counter saturation
        port_enable = 4'b1110;
        for (int i = 0; i < NUM_REQ; i++) req(i, PORT_W, 50 + i);
        n = (32'hFFFE - int'(exp_drop)) / 4;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            exp_drop = exp_drop + 16'd4;
        end
        #1;
        chk("t6.bulk", 64'(drop_cnt), 64'(exp_drop));
        rem = 32'hFFFE - int'(exp_drop);
        req_valid = 4'((1 << rem) - 1);
        cycle("t6.fill", 4'((1 << rem) - 1));
        chk("t6.fffe", 64'(drop_cnt), 64'hFFFE);
        req_valid = 4'b0111;
        cycle("t6.sat", 4'b0111);
        chk("t6.ffff", 64'(drop_cnt), 64'hFFFF);
        req_valid = 4'b1111;
        cycle("t6.hold", 4'b1111);
        chk("t6.nowrap", 64'(drop_cnt), 64'hFFFF);
        req_valid   = '0;
        port_enable = 4'hF;

        // All four ports holding, then asynchronous reset mid-cycle
        tx_ready = 4'h0;
        req(0, PORT_N, 60);
        req(1, PORT_S, 61);
        req(2, PORT_E, 62);
        req(3, PORT_W, 63);
        cycle("t7.load", 4'b1111);
        req_valid = '0;
        cycle("t7.hold", 4'b0000);
        req(0, PORT_N, 64);
        rst = 1'b1;
        #1;
        chk("t7.rst.txv",  64'(tx_valid),  64'd0);
        chk("t7.rst.rdy",  64'(req_ready), 64'd0);
        chk("t7.rst.drop", 64'(drop_cnt),  64'd0);
        for (int p = 0; p < 4; p++) q[p].delete();
        exp_drop  = '0;
        req_valid = '0;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        tx_ready = 4'hF;
        // After reset every pointer is 0: requester 0 beats requester 3
        for (int p = 0; p < 4; p++) begin
            req_valid = '0;
            req(0, p, 70 + p);
            req(3, p, 80 + p);
            cycle($sformatf("t7.ptr%0d", p), 4'b0001);
        end
        req_valid = '0;
        cycle("t7.drain", 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/noc_egress_arbiter.md
Name: noc_egress_arbiter

Overview:
- Per-core egress scheduler in front of the mesh interconnect's four directional tx ports (index 3=N, 2=S, 1=E, 0=W).
- Shares the ports between NUM_REQ internal requesters (clause-share, status, heartbeat, ...), one round-robin arbiter per port.
- Holds each port's packet in an output register so mesh valid/ready rules are met.
- Drops traffic aimed at off-grid edges so a requester never deadlocks on a port whose ready is tied low.

Parameters:
- NUM_REQ, 4, number of internal requesters (2..8).
- DROP_CNT_W, 16, width of the saturating drop counter.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- req_pkt  in  satswarmv2_pkg::noc_packet_t [NUM_REQ]  requester packets.
- req_dir  in  2 [NUM_REQ]  destination port per requester (3=N, 2=S, 1=E, 0=W).
- req_valid  in  1 [NUM_REQ]  request valid.
- req_ready  out  1 [NUM_REQ]  request accepted or dropped this cycle.
- port_enable  in  4  1 = neighbour exists on that side; 0 = off-grid edge.
- tx_pkt  out  satswarmv2_pkg::noc_packet_t [4]  to mesh core_tx.
- tx_valid  out  1 [4]  to mesh core_tx_valid.
- tx_ready  in  1 [4]  from mesh core_tx_ready.
- drop_cnt  out  DROP_CNT_W  saturating count of dropped packets.

Behaviour:
- Reset (async assert, sync release): tx_valid=0, tx_pkt=0 (msg_type MSG_STATUS, all other fields 0), RR pointers=0, drop_cnt=0. req_ready is combinational and 0 while rst=1.
- Per-port state: output register {tx_valid_q, tx_pkt_q} and RR pointer ptr[p] (clog2(NUM_REQ) bits).
- Port p "can load" = port_enable[p] && (!tx_valid_q[p] || tx_ready[p]).
- Arbitration, port p, combinational:
  - Candidates: requesters i with req_valid[i] && req_dir[i]==p.
  - Winner: first candidate searching ptr[p], ptr[p]+1, ... modulo NUM_REQ.
  - If can load and a winner exists: req_ready[winner]=1; next cycle tx_pkt_q=req_pkt[winner], tx_valid_q=1; ptr[p]=(winner+1) mod NUM_REQ.
  - Losers: req_ready=0, and must hold their request.
- Latency: request accepted in cycle N appears on tx_valid in N+1. Back-to-back grants give one packet per cycle per port when tx_ready is held high.
- Port holding (tx_valid=1, tx_ready=0): tx_pkt is stable, no new grant, pointer unchanged.
- Port fires with no winner: tx_valid_q clears next cycle.
- Requests to a port with port_enable[p]=0:
  - Every such valid requester gets req_ready=1 the same cycle; the packet is discarded.
  - drop_cnt += number dropped that cycle; saturates at all-ones and never wraps.
  - That port's pointer does not move.
- port_enable[p] falls while tx_valid_q[p]=1: the held packet is discarded next cycle (tx_valid_q=0) and drop_cnt += 1. A port is never loaded while disabled.
- Ports are independent. A requester targets exactly one port per cycle, so up to four grants can occur in one cycle.
- Simultaneous drop sources (requests + held flush) are summed in one cycle, then saturated.
- tx_valid never deasserts without a handshake except on rst or port disable.

Decomposition:
- satswarmv2_pkg gains:
  - port index constants PORT_W=0, PORT_E=1, PORT_S=2, PORT_N=3;
  - typedef noc_dir_t (logic [1:0]).
- Sub-module rr_arbiter (NUM_REQ-wide request vector + pointer in, one-hot grant + encoded index out), instantiated once per port.

Test Plan:
- Single requester 0 sends to E, tx_ready[1]=1 → req_ready[0]=1 at cycle N; tx_valid[1]=1 with identical packet at N+1; other ports stay idle.
- Requesters 0..3 all request N continuously, tx_ready[3]=1 → grants in order 0,1,2,3,0; one packet per cycle on tx_pkt[3].
- Backpressure: tx_ready[2]=0 for 5 cycles with a packet held → tx_pkt[2] stable, all req_ready to S stay 0. tx_ready rises → held packet leaves; next winner loads the same cycle and appears the cycle after.
- port_enable=4'b0110, requesters 0 and 1 target W in one cycle → both req_ready=1, drop_cnt goes 0→2, tx_valid[0] stays 0.
- Held packet on N, tx_ready=0, port_enable[3] cleared → tx_valid[3]=0 next cycle, drop_cnt+1. Separately, preload drop_cnt to 16'hFFFE and drop 3 → 16'hFFFF.
- Assert rst mid-stream with all four ports holding → all tx_valid=0 immediately; after release, the first grant on each port goes to requester 0.
